aes_hmac_out_collector: RTL and testbench
=========================================

# aes_hmac_out_collector

Downstream byte-stream collector for the AES + HMAC-SHA3 core. Samples the core's byte-serial output (one ciphertext burst, then one MAC burst per message) and reassembles it into a parallel frame {ciphertext, tag}. Presents the frame on a valid/ready port to the host-side consumer. The core cannot stall, so the block double-buffers and flags overruns and malformed bursts instead of back-pressuring.

## Interface
- CIPHER_BYTES, 16, bytes in ciphertext burst
- TAG_BYTES, 32, bytes in MAC burst
- GAP_MAX, 255, max idle cycles allowed between end of ciphertext burst and first tag byte (1..255)
- Reset is `rst_n`: synchronous, active-low. Clock is `clk`.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_data  in  8  byte from core (its o_data)
- s_valid  in  1  byte qualifier (core's o_valid); no ready
- m_cipher  out  8*CIPHER_BYTES  assembled ciphertext
- m_tag  out  8*TAG_BYTES  assembled MAC
- m_valid  out  1  frame available
- m_ready  in  1  consumer accepts frame
- err_len  out  1  1-cycle pulse: burst shorter/longer than expected
- err_ovf  out  1  1-cycle pulse: completed frame dropped, output register full
- err_timeout  out  1  1-cycle pulse: tag burst not started within GAP_MAX
- busy  out  1  frame assembly in progress (state != IDLE)

## Operation
- Byte k (0-based) of a burst lands in bits [8k+7:8k] of the work register (first byte = LSB).
- States: IDLE, CIPH (counting cipher bytes), GAP (waiting for tag), TAG (counting tag bytes), DRAIN (error recovery: wait for s_valid low).
- IDLE: s_valid=1 -> store byte 0, cnt=1, go CIPH.
- CIPH: s_valid=1 -> store byte, cnt+1.
  - After byte CIPHER_BYTES-1 is stored, go GAP with gap counter=0.
  - s_valid=0 while cnt<CIPHER_BYTES -> err_len, go IDLE.
- GAP:
  - s_valid=0 -> gap counter +1; reaching GAP_MAX -> err_timeout, go IDLE.
  - s_valid=1 on the first GAP cycle (no gap) -> err_len (cipher overlong), go DRAIN.
  - s_valid=1 otherwise -> tag byte 0, cnt=1, go TAG.
- TAG: same counting as CIPH. Short burst -> err_len, go IDLE.
  - Last tag byte (TAG_BYTES-1) completes the frame -> go IDLE; a valid on the next cycle is accepted as a new cipher burst.
- Frame completion:
  - Output register empty, or emptied this same cycle by a transfer -> load work register into m_cipher/m_tag and set m_valid.
  - Otherwise the frame is dropped and err_ovf pulses. The held frame is unchanged.
- Transfer on m_valid && m_ready. After a transfer with no simultaneous load, m_valid clears.
- DRAIN: ignore bytes; s_valid=0 -> IDLE.
- m_cipher/m_tag are stable while m_valid=1 and not transferred.

## Timing
- Reset: state IDLE, all counters 0, m_cipher=0, m_tag=0, m_valid=0, err_*=0, busy=0. Reset mid-frame discards the work register and any held frame.
- Latency: last tag byte sampled at edge N -> m_valid=1 and data valid after edge N (registered; visible the cycle following the last byte).
- Back-to-back: m_ready=1 at the completion edge -> old frame transfers and the new one loads at the same edge; m_valid stays 1; no err_ovf.
- Error pulses are single-cycle, registered, asserted the cycle after the detecting edge. At most one error per frame.
- Minimum frame spacing: CIPHER_BYTES + 1 + TAG_BYTES cycles.
- The gap counter saturates; it is only meaningful in GAP.

## Test plan
- Nominal: cipher bytes 0x00..0x0F, gap 60 cycles, tag bytes 0x20..0x3F, m_ready=1 -> m_valid for 1 cycle; m_cipher=0x0F0E..0100; m_tag=0x3F3E..2120; no errors.
- Back-pressure: hold m_ready=0, send a second full frame -> err_ovf pulse once; m_cipher/m_tag still hold the first frame. Raise m_ready -> one transfer, then m_valid=0.
- Simultaneous: complete frame 2 on the same edge m_ready=1 accepts frame 1 -> m_valid stays 1 with frame 2 data; no err_ovf.
- Short cipher burst: 10 valid bytes then s_valid=0 -> err_len; busy=0. The next full frame is collected correctly.
- Timeout: 16 cipher bytes, then s_valid=0 for GAP_MAX cycles -> err_timeout; state IDLE; no m_valid.
- Reset mid-TAG: assert rst_n=0 after 5 tag bytes while a frame is held -> all outputs 0; a fresh frame after reset is collected normally.

Source files
------------

// File: rtl/aes_hmac_out_collector_if.sv
// Byte-stream in / frame-out bundle between the AES+HMAC core output and the host consumer.
interface aes_hmac_out_collector_if #(
  parameter int unsigned CIPHER_BYTES = 16,
  parameter int unsigned TAG_BYTES    = 32
);

  logic [7:0]                s_data;
  logic                      s_valid;
  logic [8*CIPHER_BYTES-1:0] m_cipher;
  logic [8*TAG_BYTES-1:0]    m_tag;
  logic                      m_valid;
  logic                      m_ready;
  logic                      err_len;
  logic                      err_ovf;
  logic                      err_timeout;
  logic                      busy;

  // Source side: drives the byte stream and the consumer ready
  modport master (
    output s_data, s_valid, m_ready,
    input  m_cipher, m_tag, m_valid, err_len, err_ovf, err_timeout, busy
  );

  // Collector side
  modport slave (
    input  s_data, s_valid, m_ready,
    output m_cipher, m_tag, m_valid, err_len, err_ovf, err_timeout, busy
  );

endinterface

// File: rtl/aes_hmac_out_collector.sv
// Reassembles the core's byte-serial ciphertext + MAC bursts into one parallel frame.
// The core cannot stall, so completed frames are double-buffered and overruns are flagged.
module aes_hmac_out_collector #(
  parameter int unsigned CIPHER_BYTES = 16,
  parameter int unsigned TAG_BYTES    = 32,
  parameter int unsigned GAP_MAX      = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aes_hmac_out_collector_if.slave   bus
);

  localparam int unsigned CB_W  = $clog2(CIPHER_BYTES);
  localparam int unsigned TB_W  = $clog2(TAG_BYTES);
  localparam int unsigned CNT_W = (TB_W > CB_W) ? TB_W : CB_W;
  localparam int unsigned GAP_W = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CIPH,
    GAP,
    TAG,
    DRAIN
  } state_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [GAP_W-1:0]               gap_cnt;
  logic [CIPHER_BYTES-1:0][7:0]   work_cipher;
  // Last tag byte goes straight to the output register, never into the work register
  logic [TAG_BYTES-2:0][7:0]      work_tag;

  logic [8*CIPHER_BYTES-1:0]      held_cipher;
  logic [8*TAG_BYTES-1:0]         held_tag;
  logic                           held_valid;
  logic                           len_err;
  logic                           ovf_err;
  logic                           timeout_err;

  logic                           frame_done_c;
  logic [8*TAG_BYTES-1:0]         tag_full_c;

  assign frame_done_c = (state == TAG) && bus.s_valid &&
                        (cnt == CNT_W'(TAG_BYTES - 1));
  assign tag_full_c   = {bus.s_data, work_tag};

  // Burst-tracking FSM, work register and output double buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gap_cnt     <= '0;
      work_cipher <= '0;
      work_tag    <= '0;
      held_cipher <= '0;
      held_tag    <= '0;
      held_valid  <= 1'b0;
      len_err     <= 1'b0;
      ovf_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      len_err     <= 1'b0;
      ovf_err     <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            work_cipher[0] <= bus.s_data;
            cnt            <= CNT_W'(1);
            state          <= CIPH;
          end
        end

        CIPH: begin
          if (bus.s_valid) begin
            work_cipher[cnt[CB_W-1:0]] <= bus.s_data;
            if (cnt == CNT_W'(CIPHER_BYTES - 1)) begin
              cnt     <= '0;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            len_err <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end
        end

        GAP: begin
          if (bus.s_valid) begin
            // A byte with no gap at all means the cipher burst ran long
            if (gap_cnt == '0) begin
              len_err <= 1'b1;
              state   <= DRAIN;
            end else begin
              work_tag[0] <= bus.s_data;
              cnt         <= CNT_W'(1);
              state       <= TAG;
            end
          end else if (gap_cnt == GAP_W'(GAP_MAX - 1)) begin
            timeout_err <= 1'b1;
            gap_cnt     <= GAP_W'(GAP_MAX);
            state       <= IDLE;
          end else if (gap_cnt != GAP_W'(GAP_MAX)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        TAG: begin
          if (bus.s_valid) begin
            if (cnt == CNT_W'(TAG_BYTES - 1)) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              work_tag[cnt[TB_W-1:0]] <= bus.s_data;
              cnt                     <= cnt + CNT_W'(1);
            end
          end else begin
            len_err <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end
        end

        DRAIN: begin
          if (!bus.s_valid) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Load on completion if the holding register is free or being drained this edge
      if (frame_done_c) begin
        if (!held_valid || bus.m_ready) begin
          held_cipher <= work_cipher;
          held_tag    <= tag_full_c;
          held_valid  <= 1'b1;
        end else begin
          ovf_err <= 1'b1;
        end
      end else if (held_valid && bus.m_ready) begin
        held_valid <= 1'b0;
      end
    end
  end

  assign bus.m_cipher    = held_cipher;
  assign bus.m_tag       = held_tag;
  assign bus.m_valid     = held_valid;
  assign bus.err_len     = len_err;
  assign bus.err_ovf     = ovf_err;
  assign bus.err_timeout = timeout_err;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_aes_hmac_out_collector.sv
// Directed bench for aes_hmac_out_collector: drives on negedge, samples on negedge.
module tb_aes_hmac_out_collector;

  localparam int unsigned CB = 16;
  localparam int unsigned TB = 32;
  localparam int unsigned GM = 255;

  logic clk;
  logic rst_n;

  aes_hmac_out_collector_if #(.CIPHER_BYTES(CB), .TAG_BYTES(TB)) bus ();

  aes_hmac_out_collector #(
    .CIPHER_BYTES(CB),
    .TAG_BYTES   (TB),
    .GAP_MAX     (GM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int vectors;
  int miscompares;
  int n_len, n_ovf, n_to, n_xfer;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters seen at the active edge
  always @(posedge clk) begin
    if (bus.err_len)                n_len  <= n_len + 1;
    if (bus.err_ovf)                n_ovf  <= n_ovf + 1;
    if (bus.err_timeout)            n_to   <= n_to + 1;
    if (bus.m_valid && bus.m_ready) n_xfer <= n_xfer + 1;
  end

  function automatic logic [8*CB-1:0] exp_cipher(input logic [7:0] base);
    logic [8*CB-1:0] r;
    for (int k = 0; k < int'(CB); k++) r[8*k +: 8] = 8'(int'(base) + k);
    return r;
  endfunction

  function automatic logic [8*TB-1:0] exp_tag(input logic [7:0] base);
    logic [8*TB-1:0] r;
    for (int k = 0; k < int'(TB); k++) r[8*k +: 8] = 8'(int'(base) + k);
    return r;
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
  endtask

  task automatic send_burst(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) drive_byte(8'(int'(base) + k));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
    end
  endtask

  task automatic send_frame(input logic [7:0] cb, input logic [7:0] tb, input int gap);
    send_burst(cb, int'(CB));
    idle(gap);
    send_burst(tb, int'(TB));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid); end
    vectors++; if (bus.m_cipher !== '0) begin miscompares++; $display("FAIL reset_m_cipher got %h exp 0", bus.m_cipher); end
    vectors++; if (bus.m_tag !== '0) begin miscompares++; $display("FAIL reset_m_tag got %h exp 0", bus.m_tag); end
    vectors++; if (bus.err_len !== 1'b0) begin miscompares++; $display("FAIL reset_err_len got %b exp 0", bus.err_len); end
    vectors++; if (bus.err_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_err_ovf got %b exp 0", bus.err_ovf); end
    vectors++; if (bus.err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err_timeout got %b exp 0", bus.err_timeout); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    int len0, ovf0, to0, x0;
    len0 = n_len; ovf0 = n_ovf; to0 = n_to; x0 = n_xfer;
    bus.m_ready = 1'b1;
    send_burst(8'h00, int'(CB));
    idle(60);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL nominal_busy_gap got %b exp 1", bus.busy); end
    send_burst(8'h20, int'(TB));
    idle(1);
    vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL nominal_m_valid got %b exp 1", bus.m_valid); end
    vectors++; if (bus.m_cipher !== 128'h0F0E0D0C0B0A09080706050403020100) begin miscompares++; $display("FAIL nominal_m_cipher got %h exp 0F0E..0100", bus.m_cipher); end
    vectors++; if (bus.m_tag !== 256'h3F3E3D3C3B3A393837363534333231302F2E2D2C2B2A29282726252423222120) begin miscompares++; $display("FAIL nominal_m_tag got %h exp 3F3E..2120", bus.m_tag); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL nominal_busy_done got %b exp 0", bus.busy); end
    idle(1);
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL nominal_valid_clear got %b exp 0", bus.m_valid); end
    idle(2);
    vectors++; if (n_xfer - x0 !== 1) begin miscompares++; $display("FAIL nominal_xfers got %0d exp 1", n_xfer - x0); end
    vectors++; if ((n_len - len0) + (n_ovf - ovf0) + (n_to - to0) !== 0) begin miscompares++; $display("FAIL nominal_errors got %0d exp 0", (n_len - len0) + (n_ovf - ovf0) + (n_to - to0)); end
  endtask

  task automatic test_backpressure;
    int ovf0, x0;
    ovf0 = n_ovf; x0 = n_xfer;
    bus.m_ready = 1'b0;
    send_frame(8'h40, 8'h60, 5);
    idle(1);
    vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_first_valid got %b exp 1", bus.m_valid); end
    send_frame(8'h80, 8'hA0, 5);
    idle(1);
    vectors++; if (bus.err_ovf !== 1'b1) begin miscompares++; $display("FAIL bp_err_ovf got %b exp 1", bus.err_ovf); end
    vectors++; if (bus.m_cipher !== exp_cipher(8'h40)) begin miscompares++; $display("FAIL bp_held_cipher got %h exp %h", bus.m_cipher, exp_cipher(8'h40)); end
    vectors++; if (bus.m_tag !== exp_tag(8'h60)) begin miscompares++; $display("FAIL bp_held_tag got %h exp %h", bus.m_tag, exp_tag(8'h60)); end
    idle(1);
    vectors++; if (bus.err_ovf !== 1'b0) begin miscompares++; $display("FAIL bp_ovf_pulse_width got %b exp 0", bus.err_ovf); end
    vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_still_valid got %b exp 1", bus.m_valid); end
    bus.m_ready = 1'b1;
    idle(1);
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_clear got %b exp 0", bus.m_valid); end
    idle(1);
    vectors++; if (n_ovf - ovf0 !== 1) begin miscompares++; $display("FAIL bp_ovf_count got %0d exp 1", n_ovf - ovf0); end
    vectors++; if (n_xfer - x0 !== 1) begin miscompares++; $display("FAIL bp_xfers got %0d exp 1", n_xfer - x0); end
  endtask

  task automatic test_back_to_back;
    int ovf0, x0;
    ovf0 = n_ovf; x0 = n_xfer;
    bus.m_ready = 1'b0;
    send_frame(8'h10, 8'h30, 3);
    idle(1);
    vectors++; if (bus.m_tag !== exp_tag(8'h30)) begin miscompares++; $display("FAIL b2b_first_tag got %h exp %h", bus.m_tag, exp_tag(8'h30)); end
    send_frame(8'hC0, 8'hD0, 3);
    bus.m_ready = 1'b1;
    idle(1);
    vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid_held got %b exp 1", bus.m_valid); end
    vectors++; if (bus.m_cipher !== exp_cipher(8'hC0)) begin miscompares++; $display("FAIL b2b_cipher got %h exp %h", bus.m_cipher, exp_cipher(8'hC0)); end
    vectors++; if (bus.m_tag !== exp_tag(8'hD0)) begin miscompares++; $display("FAIL b2b_tag got %h exp %h", bus.m_tag, exp_tag(8'hD0)); end
    vectors++; if (bus.err_ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_err_ovf got %b exp 0", bus.err_ovf); end
    idle(1);
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_clear got %b exp 0", bus.m_valid); end
    idle(1);
    vectors++; if (n_xfer - x0 !== 2) begin miscompares++; $display("FAIL b2b_xfers got %0d exp 2", n_xfer - x0); end
    vectors++; if (n_ovf - ovf0 !== 0) begin miscompares++; $display("FAIL b2b_ovf_count got %0d exp 0", n_ovf - ovf0); end
  endtask

  task automatic test_short_cipher;
    int len0, x0;
    len0 = n_len; x0 = n_xfer;
    bus.m_ready = 1'b1;
    send_burst(8'h00, 10);
    idle(1);
    idle(1);
    vectors++; if (bus.err_len !== 1'b1) begin miscompares++; $display("FAIL short_err_len got %b exp 1", bus.err_len); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL short_busy got %b exp 0", bus.busy); end
    send_frame(8'h50, 8'h70, 4);
    idle(1);
    vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL short_next_valid got %b exp 1", bus.m_valid); end
    vectors++; if (bus.m_cipher !== exp_cipher(8'h50)) begin miscompares++; $display("FAIL short_next_cipher got %h exp %h", bus.m_cipher, exp_cipher(8'h50)); end
    vectors++; if (bus.m_tag !== exp_tag(8'h70)) begin miscompares++; $display("FAIL short_next_tag got %h exp %h", bus.m_tag, exp_tag(8'h70)); end
    idle(2);
    vectors++; if (n_len - len0 !== 1) begin miscompares++; $display("FAIL short_len_count got %0d exp 1", n_len - len0); end
    vectors++; if (n_xfer - x0 !== 1) begin miscompares++; $display("FAIL short_xfers got %0d exp 1", n_xfer - x0); end
  endtask

  task automatic test_overlong_cipher;
    bus.m_ready = 1'b1;
    send_burst(8'h00, int'(CB) + 1);
    drive_byte(8'hEE);
    vectors++; if (bus.err_len !== 1'b1) begin miscompares++; $display("FAIL long_err_len got %b exp 1", bus.err_len); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL long_drain_busy got %b exp 1", bus.busy); end
    idle(1);
    idle(1);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL long_idle_busy got %b exp 0", bus.busy); end
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL long_m_valid got %b exp 0", bus.m_valid); end
  endtask

  task automatic test_timeout;
    bus.m_ready = 1'b1;
    send_burst(8'h00, int'(CB));
    idle(int'(GM) - 1);
    idle(1);
    vectors++; if (bus.err_timeout !== 1'b0) begin miscompares++; $display("FAIL to_early got %b exp 0", bus.err_timeout); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL to_busy_before got %b exp 1", bus.busy); end
    idle(1);
    vectors++; if (bus.err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_err_timeout got %b exp 1", bus.err_timeout); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL to_busy_after got %b exp 0", bus.busy); end
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL to_m_valid got %b exp 0", bus.m_valid); end
  endtask

  task automatic test_reset_mid_tag;
    bus.m_ready = 1'b0;
    send_frame(8'h11, 8'h22, 3);
    idle(1);
    vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL rst_held_valid got %b exp 1", bus.m_valid); end
    send_burst(8'h33, int'(CB));
    idle(3);
    send_burst(8'h44, 5);
    @(negedge clk);
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid got %b exp 0", bus.m_valid); end
    vectors++; if (bus.m_cipher !== '0) begin miscompares++; $display("FAIL rst_m_cipher got %h exp 0", bus.m_cipher); end
    vectors++; if (bus.m_tag !== '0) begin miscompares++; $display("FAIL rst_m_tag got %h exp 0", bus.m_tag); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    send_frame(8'h90, 8'hB0, 2);
    idle(1);
    vectors++; if (bus.m_valid !== 1'b1) begin miscompares++; $display("FAIL rst_fresh_valid got %b exp 1", bus.m_valid); end
    vectors++; if (bus.m_cipher !== exp_cipher(8'h90)) begin miscompares++; $display("FAIL rst_fresh_cipher got %h exp %h", bus.m_cipher, exp_cipher(8'h90)); end
    vectors++; if (bus.m_tag !== exp_tag(8'hB0)) begin miscompares++; $display("FAIL rst_fresh_tag got %h exp %h", bus.m_tag, exp_tag(8'hB0)); end
    idle(1);
    vectors++; if (bus.m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_fresh_clear got %b exp 0", bus.m_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_len       = 0;
    n_ovf       = 0;
    n_to        = 0;
    n_xfer      = 0;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    test_reset();
    test_nominal();
    test_backpressure();
    test_back_to_back();
    test_short_cipher();
    test_overlong_cipher();
    test_timeout();
    test_reset_mid_tag();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
